frost32_mem_responder: RTL



---
 rtl/frost32_mem_responder_pkg.sv | 45 ++++
 rtl/frost32_byte_en_ram.sv | 35 +++
 rtl/frost32_mem_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/frost32_mem_responder_pkg.sv
// Shared types and constants for the Frost32 data-port memory responder.
//
// Contents:
//   MSB_POS__MEM_RESPONDER_WAIT  MSB index of the wait-state counter (4 bits, 0..15)
//   data_inout_access_type_t     DiatRead / DiatWrite
//   data_inout_access_size_t     Dias32 / Dias16 / Dias8 / DiasBad
//   mem_responder_state_t        StIdle / StWait / StDone
//   access_is_bad()              size/alignment rejection rule
package frost32_mem_responder_pkg;

  localparam int MSB_POS__MEM_RESPONDER_WAIT = 3;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } data_inout_access_type_t;

  typedef enum logic [1:0] {
    Dias32  = 2'd0,
    Dias16  = 2'd1,
    Dias8   = 2'd2,
    DiasBad = 2'd3
  } data_inout_access_size_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } mem_responder_state_t;

  // An access is rejected for an illegal size or a lane offset that does not
  // fit the access width within one word.
  function automatic logic access_is_bad(data_inout_access_size_t sz,
                                         logic [1:0] lo);
    logic bad;
    case (sz)
      Dias32:  bad = (lo != 2'b00);
      Dias16:  bad = lo[0];
      Dias8:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/frost32_byte_en_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
//
// Ports:
//   clk    rising-edge clock
//   en     access enable; the read register only updates when set
//   we     byte-lane write enables (lane k = bits [8k+7:8k])
//   addr   word index
//   wdata  write data, already replicated onto the addressed lanes
//   rdata  registered read data (old contents on a same-cycle write)
module frost32_byte_en_ram #(
  parameter int WORDS  = 4096,
  parameter int ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) begin
          mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/frost32_mem_responder.sv
// Default RAM slave for the Frost32 CPU data port.
//
// The CPU presents a request and holds it while stall is high. The request is
// latched in StIdle, the RAM is accessed on the edge that enters StDone after
// WAIT_STATES wait cycles, and the result is presented for the single StDone
// cycle. Reads are right-justified and zero-extended; writes merge into the
// addressed byte lanes only. Misaligned or bad-size accesses are rejected with
// a bad_access pulse and no RAM update.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_mem_access   CPU requests an access
//   addr             byte address (upper bits alias modulo the RAM size)
//   data_from_cpu    write data, right-justified for 16/8-bit writes
//   access_type      0 = read, 1 = write
//   access_size      0 = 32-bit, 1 = 16-bit, 2 = 8-bit, 3 = bad
//   data_to_cpu      read data, valid in StDone, held otherwise
//   stall            holds the CPU until the access completes
//   bad_access       one-cycle pulse in StDone for a rejected access
module frost32_mem_responder
  import frost32_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS   = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_mem_access,
  input  logic [31:0] addr,
  input  logic [31:0] data_from_cpu,
  input  logic        access_type,
  input  logic [1:0]  access_size,
  output logic [31:0] data_to_cpu,
  output logic        stall,
  output logic        bad_access
);

  localparam int WORD_AW     = $clog2(MEM_WORDS);
  localparam int BYTE_AW     = WORD_AW + 2;
  localparam int CNT_W       = MSB_POS__MEM_RESPONDER_WAIT + 1;
  localparam int WAIT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [CNT_W-1:0] WAIT_INIT = WAIT_INIT_I[CNT_W-1:0];
  localparam bit   NO_WAIT   = (WAIT_STATES == 0);

  // Lane steering helpers
  function automatic logic [3:0] lane_be(data_inout_access_size_t sz,
                                         logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      Dias32:  be = 4'b1111;
      Dias16:  be = lo[1] ? 4'b1100 : 4'b0011;
      Dias8:   be = 4'b0001 << lo;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the right-justified operand onto every lane; the byte enables
  // pick which copy lands in the RAM.
  function automatic logic [31:0] lane_wdata(data_inout_access_size_t sz,
                                             logic [31:0] d);
    logic [31:0] w;
    case (sz)
      Dias16:  w = {2{d[15:0]}};
      Dias8:   w = {4{d[7:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] read_steer(data_inout_access_size_t sz,
                                             logic [1:0] lo,
                                             logic [31:0] word);
    logic [31:0] r;
    r = '0;
    case (sz)
      Dias32: r = word;
      Dias16: r = lo[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
      Dias8: begin
        case (lo)
          2'd0:    r = {24'h0, word[7:0]};
          2'd1:    r = {24'h0, word[15:8]};
          2'd2:    r = {24'h0, word[23:16]};
          default: r = {24'h0, word[31:24]};
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  data_inout_access_type_t in_type;
  data_inout_access_size_t in_size;
  assign in_type = data_inout_access_type_t'(access_type);
  assign in_size = data_inout_access_size_t'(access_size);

  // Upper address bits alias onto the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:BYTE_AW];

  mem_responder_state_t     state_p0, state_next;
  logic [CNT_W-1:0]         cnt_p0, cnt_next;
  logic                     stall_raw;

  logic [BYTE_AW-1:0]       req_addr_p0;
  logic [31:0]              req_data_p0;
  data_inout_access_type_t  req_type_p0;
  data_inout_access_size_t  req_size_p0;
  logic                     req_bad_p0;

  logic [BYTE_AW-1:0]       acc_addr;
  logic [31:0]              acc_data;
  data_inout_access_type_t  acc_type;
  data_inout_access_size_t  acc_size;
  logic                     acc_bad;
  logic                     exec;

  logic                     ram_en;
  logic [3:0]               ram_we;
  logic [31:0]              ram_wdata;
  logic [31:0]              ram_rdata;

  logic [31:0]              done_data;
  logic [31:0]              data_hold_p1;

  // FSM next-state and stall
  always_comb begin
    state_next = state_p0;
    cnt_next   = cnt_p0;
    stall_raw  = 1'b0;
    case (state_p0)
      StIdle: begin
        stall_raw = req_mem_access;
        if (req_mem_access) begin
          state_next = NO_WAIT ? StDone : StWait;
          cnt_next   = WAIT_INIT;
        end
      end
      StWait: begin
        stall_raw = 1'b1;
        if (cnt_p0 == '0) begin
          state_next = StDone;
        end else begin
          cnt_next = cnt_p0 - 1'b1;
        end
      end
      StDone: begin
        state_next = StIdle;
      end
      default: begin
        state_next = StIdle;
      end
    endcase
  end

  // Held low through reset regardless of a pending request.
  assign stall = rst_n & stall_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= StIdle;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_next;
      cnt_p0   <= cnt_next;
    end
  end

  // ---- stage p0: request latch ----
  always_ff @(posedge clk) begin
    if (state_p0 == StIdle && req_mem_access) begin
      req_addr_p0 <= addr[BYTE_AW-1:0];
      req_data_p0 <= data_from_cpu;
      req_type_p0 <= in_type;
      req_size_p0 <= in_size;
      req_bad_p0  <= access_is_bad(in_size, addr[1:0]);
    end
  end

  // With no wait states the RAM is accessed on the accepting edge, so the
  // live inputs drive it; otherwise the latched copy does.
  always_comb begin
    acc_addr = req_addr_p0;
    acc_data = req_data_p0;
    acc_type = req_type_p0;
    acc_size = req_size_p0;
    if (state_p0 == StIdle) begin
      acc_addr = addr[BYTE_AW-1:0];
      acc_data = data_from_cpu;
      acc_type = in_type;
      acc_size = in_size;
    end
  end

  assign acc_bad = access_is_bad(acc_size, acc_addr[1:0]);

  // rst_n gating keeps an asynchronously reset access from writing.
  assign exec = rst_n &
                ((NO_WAIT && state_p0 == StIdle && req_mem_access) ||
                 (state_p0 == StWait && cnt_p0 == '0));

  assign ram_en    = exec;
  assign ram_we    = (exec && acc_type == DiatWrite && !acc_bad)
                     ? lane_be(acc_size, acc_addr[1:0]) : 4'b0000;
  assign ram_wdata = lane_wdata(acc_size, acc_data);

  // ---- stage p1: RAM access ----
  frost32_byte_en_ram #(
    .WORDS (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (acc_addr[BYTE_AW-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign done_data = (req_bad_p0 || req_type_p0 == DiatWrite)
                     ? 32'h0
                     : read_steer(req_size_p0, req_addr_p0[1:0], ram_rdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_hold_p1 <= '0;
    end else if (state_p0 == StDone) begin
      data_hold_p1 <= done_data;
    end
  end

  assign data_to_cpu = (state_p0 == StDone) ? done_data : data_hold_p1;
  assign bad_access  = (state_p0 == StDone) && req_bad_p0;

endmodule
